// File: rtl/fxp_pkg.sv
// fxp_pkg: shared definitions for the fixed-point streaming stages.
//   - fxp_state_e   : accumulator FSM states (ACCUM, HOLD)
//   - FXP_*         : default Q-format widths and the widest supported datapath
//   - fxp_clamp     : clamp a signed value to a given two's complement width
//   - fxp_sat_add   : signed add, clamped to a given width
// The helpers compute on an FXP_MAXW-bit signed carrier so they serve any
// configured width up to FXP_MAXW-2 bits; callers size-cast the result down.
package fxp_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } fxp_state_e;

  localparam int unsigned FXP_WHOLE = 16;
  localparam int unsigned FXP_FRAC  = 16;
  localparam int unsigned FXP_GUARD = 8;
  localparam int unsigned FXP_COUNT = 8;
  localparam int unsigned FXP_MAXW  = 128;

  // Clamp v into the signed range of 'width' bits; flags whether it moved.
  function automatic logic signed [FXP_MAXW-1:0] fxp_clamp(
    input  logic signed [FXP_MAXW-1:0] v,
    input  int unsigned                width,
    output logic                       clamped
  );
    logic signed [FXP_MAXW-1:0] hi;
    logic signed [FXP_MAXW-1:0] lo;
    logic signed [FXP_MAXW-1:0] res;
    hi = (128'sd1 <<< (width - 32'd1)) - 128'sd1;
    lo = -hi - 128'sd1;
    if (v > hi) begin
      res     = hi;
      clamped = 1'b1;
    end else if (v < lo) begin
      res     = lo;
      clamped = 1'b1;
    end else begin
      res     = v;
      clamped = 1'b0;
    end
    return res;
  endfunction

  // Operands are already within 'width' bits, so the carrier never wraps.
  function automatic logic signed [FXP_MAXW-1:0] fxp_sat_add(
    input  logic signed [FXP_MAXW-1:0] a,
    input  logic signed [FXP_MAXW-1:0] b,
    input  int unsigned                width,
    output logic                       ovf
  );
    return fxp_clamp(a + b, width, ovf);
  endfunction

endpackage

// File: rtl/fxp_saturate.sv
// fxp_saturate: combinational signed clamp from inWidth to outWidth bits.
// Ports:
//   din     in  inWidth   signed value to narrow
//   dout    out outWidth  din clamped to the outWidth signed range
//   clamped out 1         din lay outside the outWidth range
module fxp_saturate
  import fxp_pkg::*;
#(
  parameter int unsigned inWidth  = 40,
  parameter int unsigned outWidth = 32
) (
  input  logic [inWidth-1:0]  din,
  output logic [outWidth-1:0] dout,
  output logic                clamped
);

  logic signed [FXP_MAXW-1:0] clamp_full;
  logic                       clamp_flag;

  always_comb begin
    clamp_full = fxp_clamp(FXP_MAXW'(signed'(din)), outWidth, clamp_flag);
  end

  assign dout    = outWidth'(clamp_full);
  assign clamped = clamp_flag;

endmodule

// File: rtl/fxp_accumulate.sv
// fxp_accumulate: streaming saturating dot-product accumulator.
// Sums a block of signed Qw.f products in an A-bit accumulator (W plus guard
// bits) that saturates internally, then presents one W-bit clamped result.
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   clear                 synchronous abort of the block being accumulated
//   in_valid/in_ready     product beat handshake; in_last marks final term
//   product               signed Qw.f term
//   sum_valid/sum_ready   result handshake
//   sum                   saturated signed Qw.f block sum
//   overflow              any saturation (internal or output) in the block
//   term_count            beats in the block, saturating at all-ones
module fxp_accumulate
  import fxp_pkg::*;
#(
  parameter  int unsigned wholeWidth    = FXP_WHOLE,
  parameter  int unsigned fractionWidth = FXP_FRAC,
  parameter  int unsigned guardBits     = FXP_GUARD,
  parameter  int unsigned countWidth    = FXP_COUNT,
  localparam int unsigned W             = wholeWidth + fractionWidth,
  localparam int unsigned A             = W + guardBits
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [W-1:0]          product,
  output logic                  sum_valid,
  input  logic                  sum_ready,
  output logic [W-1:0]          sum,
  output logic                  overflow,
  output logic [countWidth-1:0] term_count
);

  fxp_state_e            state_q, state_d;
  logic [A-1:0]          acc_q, acc_d, acc_sum;
  logic                  ovf_q, ovf_d, add_ovf;
  logic [countWidth-1:0] cnt_q, cnt_d, cnt_inc;
  logic [W-1:0]          sum_q, sum_d, sat_sum;
  logic                  overflow_q, overflow_d, sat_clamped;
  logic [countWidth-1:0] term_count_q, term_count_d;
  logic                  accept;

  // Candidate accumulator and counter values if the current beat is taken.
  always_comb begin
    acc_sum = A'(fxp_sat_add(FXP_MAXW'(signed'(acc_q)), FXP_MAXW'(signed'(product)),
                             A, add_ovf));
    cnt_inc = (cnt_q == {countWidth{1'b1}}) ? cnt_q : cnt_q + countWidth'(1'b1);
  end

  // Final narrowing operates on the post-add value so the last beat counts.
  fxp_saturate #(
    .inWidth (A),
    .outWidth(W)
  ) u_sat (
    .din    (acc_sum),
    .dout   (sat_sum),
    .clamped(sat_clamped)
  );

  assign in_ready   = (state_q == ACCUM) && !clear;
  assign accept     = in_valid && in_ready;
  assign sum_valid  = (state_q == HOLD);
  assign sum        = sum_q;
  assign overflow   = overflow_q;
  assign term_count = term_count_q;

  // Next-state logic: accumulate, close a block, or wait for the consumer.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    ovf_d        = ovf_q;
    cnt_d        = cnt_q;
    sum_d        = sum_q;
    overflow_d   = overflow_q;
    term_count_d = term_count_q;
    case (state_q)
      ACCUM: begin
        if (clear) begin
          acc_d = '0;
          ovf_d = 1'b0;
          cnt_d = '0;
        end else if (accept && in_last) begin
          sum_d        = sat_sum;
          overflow_d   = ovf_q | add_ovf | sat_clamped;
          term_count_d = cnt_inc;
          acc_d        = '0;
          ovf_d        = 1'b0;
          cnt_d        = '0;
          state_d      = HOLD;
        end else if (accept) begin
          acc_d = acc_sum;
          ovf_d = ovf_q | add_ovf;
          cnt_d = cnt_inc;
        end else begin
          state_d = ACCUM;
        end
      end
      HOLD: begin
        // clear is deliberately ignored here: the pending result survives.
        if (sum_ready) begin
          state_d = ACCUM;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ACCUM;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      cnt_q        <= '0;
      sum_q        <= '0;
      overflow_q   <= 1'b0;
      term_count_q <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      ovf_q        <= ovf_d;
      cnt_q        <= cnt_d;
      sum_q        <= sum_d;
      overflow_q   <= overflow_d;
      term_count_q <= term_count_d;
    end
  end

endmodule

// File: tb/tb_fxp_accumulate.sv
// tb_fxp_accumulate: self-checking bench for fxp_accumulate (Q16.16, 8 guard
// bits, 8-bit counter) plus a countWidth=2 instance for counter saturation.
module tb_fxp_accumulate;

  logic        clock = 1'b0;
  logic        reset;
  logic        clear, in_valid, in_last, sum_ready;
  logic [31:0] product;
  logic        in_ready, sum_valid, overflow;
  logic [31:0] sum;
  logic [7:0]  term_count;

  logic        c2_clear, c2_in_valid, c2_in_last, c2_sum_ready;
  logic [31:0] c2_product;
  logic        c2_in_ready, c2_sum_valid, c2_overflow;
  logic [31:0] c2_sum;
  logic [1:0]  c2_term_count;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  fxp_accumulate dut (
    .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .product(product),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .sum(sum),
    .overflow(overflow), .term_count(term_count)
  );

  fxp_accumulate #(.countWidth(2)) dut2 (
    .clock(clock), .reset(reset), .clear(c2_clear), .in_valid(c2_in_valid),
    .in_ready(c2_in_ready), .in_last(c2_in_last), .product(c2_product),
    .sum_valid(c2_sum_valid), .sum_ready(c2_sum_ready), .sum(c2_sum),
    .overflow(c2_overflow), .term_count(c2_term_count)
  );

  // Reference: exact integer sum, clamped to 40 bits after every term and to
  // 32 bits at the end; counter stops at cmax.
  function automatic void ref_block(input logic [31:0] q[$], input int cmax,
                                    output logic [31:0] s, output logic o, output int c);
    longint acc  = 0;
    longint amax = (longint'(1) <<< 39) - 1;
    longint amin = -(longint'(1) <<< 39);
    longint wmax = (longint'(1) <<< 31) - 1;
    longint wmin = -(longint'(1) <<< 31);
    o = 1'b0;
    c = 0;
    foreach (q[i]) begin
      acc = acc + longint'($signed(q[i]));
      if (acc > amax) begin acc = amax; o = 1'b1; end
      if (acc < amin) begin acc = amin; o = 1'b1; end
      if (c < cmax) c++;
    end
    if (acc > wmax) begin s = 32'h7FFF_FFFF; o = 1'b1; end
    else if (acc < wmin) begin s = 32'h8000_0000; o = 1'b1; end
    else s = acc[31:0];
  endfunction

  // Drive one block back to back; returns at the negedge after the last beat.
  task automatic drive_block(input logic [31:0] q[$]);
    foreach (q[i]) begin
      @(negedge clock);
      in_valid = 1'b1;
      product  = q[i];
      in_last  = (i == q.size() - 1);
      @(posedge clock);
    end
    @(negedge clock);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Complete the result handshake; returns at a negedge back in ACCUM.
  task automatic take_result();
    @(negedge clock);
    sum_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    sum_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (sum_valid !== 1'b0) begin bad++; $display("FAIL reset_sum_valid got=%b exp=0", sum_valid); end
    total++; if (sum !== 32'h0) begin bad++; $display("FAIL reset_sum got=%h exp=0", sum); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    total++; if (term_count !== 8'd0) begin bad++; $display("FAIL reset_term_count got=%0d exp=0", term_count); end
  endtask

  task automatic test_basic();
    logic [31:0] q[$];
    q = {32'h0001_8000, 32'h0002_4000};
    drive_block(q);
    total++; if (sum_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", sum_valid); end
    total++; if (sum !== 32'h0003_C000) begin bad++; $display("FAIL basic_sum got=%h exp=0003c000", sum); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL basic_overflow got=%b exp=0", overflow); end
    total++; if (term_count !== 8'd2) begin bad++; $display("FAIL basic_count got=%0d exp=2", term_count); end
    take_result();
    total++; if (sum_valid !== 1'b0) begin bad++; $display("FAIL basic_handshake got=%b exp=0", sum_valid); end
  endtask

  task automatic test_negative();
    logic [31:0] q[$];
    q = {32'hFFFF_0000};
    drive_block(q);
    total++; if (sum !== 32'hFFFF_0000) begin bad++; $display("FAIL neg1_sum got=%h exp=ffff0000", sum); end
    total++; if (term_count !== 8'd1) begin bad++; $display("FAIL neg1_count got=%0d exp=1", term_count); end
    take_result();
    q = {32'hFFFF_0000, 32'h0000_8000};
    drive_block(q);
    total++; if (sum !== 32'hFFFF_8000) begin bad++; $display("FAIL neg2_sum got=%h exp=ffff8000", sum); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL neg2_overflow got=%b exp=0", overflow); end
    take_result();
  endtask

  task automatic test_saturation();
    logic [31:0] q[$];
    q = {32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000};
    drive_block(q);
    total++; if (sum !== 32'h7FFF_FFFF) begin bad++; $display("FAIL sat_sum got=%h exp=7fffffff", sum); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL sat_overflow got=%b exp=1", overflow); end
    take_result();
    q = {32'h0000_0001};
    drive_block(q);
    total++; if (sum !== 32'h0000_0001) begin bad++; $display("FAIL sat_next_sum got=%h exp=00000001", sum); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL sat_next_overflow got=%b exp=0", overflow); end
    take_result();
  endtask

  task automatic test_backpressure();
    logic [31:0] q[$];
    q = {32'h0003_0000, 32'h0000_1000};
    drive_block(q);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      in_valid = 1'b1;
      product  = 32'h1234_0000;
      in_last  = 1'b1;
      #1;
      total++; if (sum_valid !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, sum_valid); end
      total++; if (sum !== 32'h0003_1000) begin bad++; $display("FAIL bp_sum cyc=%0d got=%h exp=00031000", i, sum); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
    end
    @(negedge clock);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    sum_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    sum_ready = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    total++; if (sum_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b exp=0", sum_valid); end
    q = {32'h0001_0000};
    drive_block(q);
    total++; if (sum !== 32'h0001_0000) begin bad++; $display("FAIL bp_after_sum got=%h exp=00010000", sum); end
    total++; if (term_count !== 8'd1) begin bad++; $display("FAIL bp_after_count got=%0d exp=1", term_count); end
    take_result();
  endtask

  task automatic test_clear();
    logic [31:0] q[$];
    @(negedge clock);
    in_valid = 1'b1;
    product  = 32'h0005_0000;
    in_last  = 1'b0;
    @(posedge clock);
    @(negedge clock);
    clear   = 1'b1;
    product = 32'h0009_0000;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL clear_in_ready got=%b exp=0", in_ready); end
    @(posedge clock);
    @(negedge clock);
    clear    = 1'b0;
    in_valid = 1'b0;
    q = {32'h0001_0000};
    drive_block(q);
    total++; if (sum !== 32'h0001_0000) begin bad++; $display("FAIL clear_sum got=%h exp=00010000", sum); end
    total++; if (term_count !== 8'd1) begin bad++; $display("FAIL clear_count got=%0d exp=1", term_count); end
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    @(negedge clock);
    clear = 1'b0;
    total++; if (sum_valid !== 1'b1) begin bad++; $display("FAIL clear_hold_valid got=%b exp=1", sum_valid); end
    total++; if (sum !== 32'h0001_0000) begin bad++; $display("FAIL clear_hold_sum got=%h exp=00010000", sum); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] q[$];
    // Result from test_clear is still pending: reset while in HOLD.
    @(negedge clock);
    reset = 1'b1;
    #1;
    total++; if (sum_valid !== 1'b0) begin bad++; $display("FAIL rst_hold_valid got=%b exp=0", sum_valid); end
    total++; if (sum !== 32'h0) begin bad++; $display("FAIL rst_hold_sum got=%h exp=0", sum); end
    total++; if (term_count !== 8'd0) begin bad++; $display("FAIL rst_hold_count got=%0d exp=0", term_count); end
    @(negedge clock);
    reset    = 1'b0;
    in_valid = 1'b1;
    product  = 32'h0007_0000;
    in_last  = 1'b0;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b exp=1", in_ready); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_mid_overflow got=%b exp=0", overflow); end
    @(negedge clock);
    reset = 1'b0;
    q = {32'h0002_0000};
    drive_block(q);
    total++; if (sum !== 32'h0002_0000) begin bad++; $display("FAIL rst_mid_sum got=%h exp=00020000", sum); end
    total++; if (term_count !== 8'd1) begin bad++; $display("FAIL rst_mid_count got=%0d exp=1", term_count); end
    take_result();
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic [31:0] es;
    logic        eo;
    int          ec;
    for (int b = 0; b < 30; b++) begin
      q.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
        case ($urandom_range(0, 3))
          0: q.push_back($urandom);
          1: q.push_back(32'($signed(16'($urandom))));
          2: q.push_back({16'h7FFF, 16'($urandom)});
          default: q.push_back({16'h8000, 16'($urandom)});
        endcase
      end
      ref_block(q, 255, es, eo, ec);
      drive_block(q);
      repeat ($urandom_range(0, 3)) @(negedge clock);
      total++; if (sum !== es) begin bad++; $display("FAIL rnd_sum blk=%0d got=%h exp=%h", b, sum, es); end
      total++; if (overflow !== eo) begin bad++; $display("FAIL rnd_overflow blk=%0d got=%b exp=%b", b, overflow, eo); end
      total++; if (term_count !== 8'(ec)) begin bad++; $display("FAIL rnd_count blk=%0d got=%0d exp=%0d", b, term_count, ec); end
      take_result();
    end
  endtask

  task automatic test_long_block();
    logic [31:0] q[$];
    for (int i = 0; i < 300; i++) q.push_back(32'h7FFF_FFFF);
    for (int i = 0; i < 256; i++) q.push_back(32'h8000_0000);
    // Internal clamp at 2^39-1 then -2^39 brings it to -1: sticky overflow.
    drive_block(q);
    total++; if (sum !== 32'hFFFF_FFFF) begin bad++; $display("FAIL long_sum got=%h exp=ffffffff", sum); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL long_overflow got=%b exp=1", overflow); end
    total++; if (term_count !== 8'd255) begin bad++; $display("FAIL long_count got=%0d exp=255", term_count); end
    take_result();
  endtask

  task automatic test_count_sat2();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      c2_in_valid = 1'b1;
      c2_product  = 32'h0;
      c2_in_last  = (i == 5);
      @(posedge clock);
    end
    @(negedge clock);
    c2_in_valid = 1'b0;
    c2_in_last  = 1'b0;
    total++; if (c2_sum_valid !== 1'b1) begin bad++; $display("FAIL c2_valid got=%b exp=1", c2_sum_valid); end
    total++; if (c2_term_count !== 2'd3) begin bad++; $display("FAIL c2_count got=%0d exp=3", c2_term_count); end
    total++; if (c2_sum !== 32'h0) begin bad++; $display("FAIL c2_sum got=%h exp=0", c2_sum); end
    @(negedge clock);
    c2_sum_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    c2_sum_ready = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    clear        = 1'b0;
    in_valid     = 1'b0;
    in_last      = 1'b0;
    sum_ready    = 1'b0;
    product      = 32'h0;
    c2_clear     = 1'b0;
    c2_in_valid  = 1'b0;
    c2_in_last   = 1'b0;
    c2_sum_ready = 1'b0;
    c2_product   = 32'h0;
    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_backpressure();
    test_clear();
    test_reset_mid();
    test_random();
    test_long_block();
    test_count_sat2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
